// File: rtl/decode_execute_stage.sv
// Decode->Execute pipeline register with execute-operand forwarding muxes.
// Define PIPE_PERF_CNT_EN to add saturating bubble/flush performance counters.
module decode_execute_stage #(
    parameter int         DATA_WIDTH = 32,
    parameter logic [6:0] NOP_OPCODE = 7'b0010011
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int         CNT_WIDTH  = 32
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  D_E_en,
    input  logic                  no_op,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] d_pc,
    input  logic [DATA_WIDTH-1:0] d_imm,
    input  logic [DATA_WIDTH-1:0] d_rd1,
    input  logic [DATA_WIDTH-1:0] d_rd2,
    input  logic [4:0]            d_reg_a,
    input  logic [4:0]            d_reg_b,
    input  logic [4:0]            d_reg_d,
    input  logic [6:0]            d_opcode,
    input  logic [2:0]            d_funct3,
    input  logic                  d_reg_write_enable,
    input  logic                  d_mem_write,
    input  logic [1:0]            fwd_a,
    input  logic [1:0]            fwd_b,
    input  logic [DATA_WIDTH-1:0] m_alu_result,
    input  logic [DATA_WIDTH-1:0] w_result,
    output logic [DATA_WIDTH-1:0] E_pc,
    output logic [DATA_WIDTH-1:0] E_imm,
    output logic [4:0]            ex_reg_a,
    output logic [4:0]            ex_reg_b,
    output logic [4:0]            ex_reg_d,
    output logic [6:0]            E_opcode,
    output logic [2:0]            E_funct3,
    output logic                  E_reg_write_enable,
    output logic                  E_mem_write,
    output logic                  E_valid,
    output logic [DATA_WIDTH-1:0] E_src_a,
    output logic [DATA_WIDTH-1:0] E_src_b
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  bubble_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

    logic [DATA_WIDTH-1:0] E_rd1;
    logic [DATA_WIDTH-1:0] E_rd2;

    // A bubble clears every control field in the same edge so the hazard unit
    // never sees register addresses that disagree with E_opcode.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            E_pc               <= '0;
            E_imm              <= '0;
            E_rd1              <= '0;
            E_rd2              <= '0;
            ex_reg_a           <= '0;
            ex_reg_b           <= '0;
            ex_reg_d           <= '0;
            E_opcode           <= NOP_OPCODE;
            E_funct3           <= '0;
            E_reg_write_enable <= 1'b0;
            E_mem_write        <= 1'b0;
            E_valid            <= 1'b0;
        end else if (flush || no_op) begin
            ex_reg_a           <= '0;
            ex_reg_b           <= '0;
            ex_reg_d           <= '0;
            E_opcode           <= NOP_OPCODE;
            E_reg_write_enable <= 1'b0;
            E_mem_write        <= 1'b0;
            E_valid            <= 1'b0;
        end else if (D_E_en) begin
            E_pc               <= d_pc;
            E_imm              <= d_imm;
            E_rd1              <= d_rd1;
            E_rd2              <= d_rd2;
            ex_reg_a           <= d_reg_a;
            ex_reg_b           <= d_reg_b;
            ex_reg_d           <= d_reg_d;
            E_opcode           <= d_opcode;
            E_funct3           <= d_funct3;
            E_reg_write_enable <= d_reg_write_enable;
            E_mem_write        <= d_mem_write;
            E_valid            <= 1'b1;
        end
    end

    // Select 2'b11 is reserved and falls back to the register-file value.
    // NOTE: each output gets a default before the case so no latch is inferred.
    always_comb begin
        E_src_a = E_rd1;
        case (fwd_a)
            2'b01:   E_src_a = m_alu_result;
            2'b10:   E_src_a = w_result;
            default: E_src_a = E_rd1;
        endcase
        E_src_b = E_rd2;
        case (fwd_b)
            2'b01:   E_src_b = m_alu_result;
            2'b10:   E_src_b = w_result;
            default: E_src_b = E_rd2;
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    // A simultaneous flush and no_op counts once, as a flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end else if (no_op) begin
            if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: expected E state queued at drive time,
// compared one cycle later; forwarding mux and async reset checked directly.
module tb_decode_execute_stage;

    localparam logic [6:0] NOP = 7'b0010011;

    typedef struct {
        logic [31:0] pc, imm, rd1, rd2;
        logic [4:0]  ra, rb, rd;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        we, mw, valid;
    } stage_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        D_E_en, no_op, flush;
    logic [31:0] d_pc, d_imm, d_rd1, d_rd2;
    logic [4:0]  d_reg_a, d_reg_b, d_reg_d;
    logic [6:0]  d_opcode;
    logic [2:0]  d_funct3;
    logic        d_reg_write_enable, d_mem_write;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] m_alu_result, w_result;
    logic [31:0] E_pc, E_imm, E_src_a, E_src_b;
    logic [4:0]  ex_reg_a, ex_reg_b, ex_reg_d;
    logic [6:0]  E_opcode;
    logic [2:0]  E_funct3;
    logic        E_reg_write_enable, E_mem_write, E_valid;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    decode_execute_stage dut (
        .clk(clk), .rst_n(rst_n), .D_E_en(D_E_en), .no_op(no_op), .flush(flush),
        .d_pc(d_pc), .d_imm(d_imm), .d_rd1(d_rd1), .d_rd2(d_rd2),
        .d_reg_a(d_reg_a), .d_reg_b(d_reg_b), .d_reg_d(d_reg_d),
        .d_opcode(d_opcode), .d_funct3(d_funct3),
        .d_reg_write_enable(d_reg_write_enable), .d_mem_write(d_mem_write),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .m_alu_result(m_alu_result), .w_result(w_result),
        .E_pc(E_pc), .E_imm(E_imm), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b),
        .ex_reg_d(ex_reg_d), .E_opcode(E_opcode), .E_funct3(E_funct3),
        .E_reg_write_enable(E_reg_write_enable), .E_mem_write(E_mem_write),
        .E_valid(E_valid), .E_src_a(E_src_a), .E_src_b(E_src_b)
`ifdef PIPE_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_fail   = 0;
    stage_t model;
    stage_t sb[$];
    int     bubble_exp = 0;
    int     flush_exp  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic stage_t reset_state();
        stage_t s;
        s = '{pc: 0, imm: 0, rd1: 0, rd2: 0, ra: 0, rb: 0, rd: 0,
              op: NOP, f3: 0, we: 0, mw: 0, valid: 0};
        return s;
    endfunction

    // Data fields are only meaningful (and only compared) while E holds a real instruction.
    task automatic compare_state(input stage_t e);
        check("E_opcode", 32'(E_opcode), 32'(e.op));
        check("ex_reg_a", 32'(ex_reg_a), 32'(e.ra));
        check("ex_reg_b", 32'(ex_reg_b), 32'(e.rb));
        check("ex_reg_d", 32'(ex_reg_d), 32'(e.rd));
        check("E_reg_write_enable", 32'(E_reg_write_enable), 32'(e.we));
        check("E_mem_write", 32'(E_mem_write), 32'(e.mw));
        check("E_valid", 32'(E_valid), 32'(e.valid));
        if (e.valid) begin
            check("E_funct3", 32'(E_funct3), 32'(e.f3));
            check("E_pc", E_pc, e.pc);
            check("E_imm", E_imm, e.imm);
            check("E_src_a", E_src_a, e.rd1);
            check("E_src_b", E_src_b, e.rd2);
        end
`ifdef PIPE_PERF_CNT_EN
        check("bubble_cnt", bubble_cnt, 32'(bubble_exp));
        check("flush_cnt", flush_cnt, 32'(flush_exp));
`endif
    endtask

    // Drive one cycle at the falling edge, predict the next E state, compare after the rising edge.
    task automatic drive_cycle(input logic en, input logic nop, input logic fl, input stage_t d);
        @(negedge clk);
        D_E_en = en; no_op = nop; flush = fl;
        d_pc = d.pc; d_imm = d.imm; d_rd1 = d.rd1; d_rd2 = d.rd2;
        d_reg_a = d.ra; d_reg_b = d.rb; d_reg_d = d.rd;
        d_opcode = d.op; d_funct3 = d.f3;
        d_reg_write_enable = d.we; d_mem_write = d.mw;
        if (fl || nop) begin
            model.op = NOP; model.ra = 0; model.rb = 0; model.rd = 0;
            model.we = 0; model.mw = 0; model.valid = 0;
            if (fl) flush_exp++;
            else    bubble_exp++;
        end else if (en) begin
            model = d;
            model.valid = 1'b1;
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        compare_state(sb.pop_front());
    endtask

    function automatic stage_t mk(input logic [6:0] op, input logic [4:0] rd,
                                  input logic we, input logic mw, input logic [31:0] seed);
        stage_t s;
        s = '{pc: 32'h100 + seed, imm: seed ^ 32'h5a5a, rd1: seed * 3, rd2: ~seed,
              ra: 5'(seed), rb: 5'(seed >> 5), rd: rd, op: op, f3: 3'(seed >> 2),
              we: we, mw: mw, valid: 1'b0};
        return s;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stage_t d;
        rst_n = 1'b0; D_E_en = 1'b0; no_op = 1'b0; flush = 1'b0;
        fwd_a = 2'b00; fwd_b = 2'b00; m_alu_result = '0; w_result = '0;
        d = mk(7'b0110011, 5'd1, 1'b1, 1'b0, 32'd1);
        drive_d: begin
            d_pc = d.pc; d_imm = d.imm; d_rd1 = d.rd1; d_rd2 = d.rd2;
            d_reg_a = d.ra; d_reg_b = d.rb; d_reg_d = d.rd;
            d_opcode = d.op; d_funct3 = d.f3;
            d_reg_write_enable = 1'b1; d_mem_write = 1'b1;
        end
        model = reset_state();
        #12;
        check("rst E_pc", E_pc, 32'h0);
        check("rst E_imm", E_imm, 32'h0);
        check("rst E_src_a", E_src_a, 32'h0);
        compare_state(model);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type load, one cycle latency
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0110011, 5'd5, 1'b1, 1'b0, 32'd7));
        // lw x5 followed by a load-use bubble
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0000011, 5'd5, 1'b1, 1'b0, 32'd9));
        drive_cycle(1'b0, 1'b1, 1'b0, mk(7'b0110011, 5'd6, 1'b1, 1'b0, 32'd11));
        // real instruction then three held cycles with toggling D fields
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0010011, 5'd12, 1'b1, 1'b0, 32'd21));
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b0, 1'b0, 1'b0, mk(7'(i * 37), 5'(i + 20), i[0], ~i[0], 32'(i * 1000 + 3)));
        // flush with no_op: one flush, no bubble count
        drive_cycle(1'b0, 1'b1, 1'b1, mk(7'b1100011, 5'd3, 1'b1, 1'b1, 32'd33));
        // flush beats a load
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0100011, 5'd0, 1'b0, 1'b1, 32'd40));
        drive_cycle(1'b1, 1'b0, 1'b1, mk(7'b0110011, 5'd8, 1'b1, 1'b0, 32'd41));

        // forwarding mux, switching selects inside one cycle
        d = mk(7'b0110011, 5'd9, 1'b1, 1'b0, 32'd50);
        d.rd1 = 32'h11; d.rd2 = 32'h44;
        drive_cycle(1'b1, 1'b0, 1'b0, d);
        m_alu_result = 32'h22; w_result = 32'h33;
        fwd_a = 2'b01; #1 check("fwd_a=01", E_src_a, 32'h22);
        fwd_a = 2'b10; #1 check("fwd_a=10", E_src_a, 32'h33);
        fwd_a = 2'b11; #1 check("fwd_a=11", E_src_a, 32'h11);
        fwd_b = 2'b01; #1 check("fwd_b=01", E_src_b, 32'h22);
        fwd_b = 2'b10; #1 check("fwd_b=10", E_src_b, 32'h33);
        fwd_b = 2'b11; #1 check("fwd_b=11", E_src_b, 32'h44);
        fwd_a = 2'b00; fwd_b = 2'b00;
        #1 check("fwd_a=00", E_src_a, 32'h11);

        // random mix of loads, holds, bubbles and flushes
        for (int i = 0; i < 24; i++)
            drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                        1'($urandom_range(0, 5) == 0),
                        mk(7'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), $urandom));

        // asynchronous reset in the middle of a loaded cycle
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0110011, 5'd17, 1'b1, 1'b1, 32'd77));
        #2;
        rst_n = 1'b0; D_E_en = 1'b0; no_op = 1'b0; flush = 1'b0;
        #1;
        model = reset_state();
        bubble_exp = 0; flush_exp = 0;
        check("async E_pc", E_pc, 32'h0);
        check("async E_src_a", E_src_a, 32'h0);
        compare_state(model);

        // release during a stall: stage stays empty until the first load
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b0, 1'b0, 1'b0, mk(7'b0110011, 5'd18, 1'b1, 1'b0, 32'd80));
        drive_cycle(1'b1, 1'b0, 1'b0, mk(7'b0110011, 5'd19, 1'b1, 1'b0, 32'd81));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
